// File: rtl/count_stepper_if.sv
// Command and downstream-counter bundle for count_stepper.
// The master offers commands; the slave drives the counter controls.
interface count_stepper_if #(
    parameter int WIDTH = 16
);
    logic             start_valid;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] target;
    logic             abort;
    logic             start_ready;
    logic             load;
    logic [WIDTH-1:0] I;
    logic             direction;
    logic [2:0]       value;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] shadow;

    modport master (
        output start_valid, base, target, abort,
        input  start_ready, load, I, direction, value, busy, done, shadow
    );

    modport slave (
        input  start_valid, base, target, abort,
        output start_ready, load, I, direction, value, busy, done, shadow
    );
endinterface

// File: rtl/count_stepper.sv
// Drives a loadable up/down counter from base to target in bounded steps.
// All outputs are registered; shadow tracks the counter's resulting value.
module count_stepper #(
    parameter int WIDTH    = 16,
    parameter int MAX_STEP = 7
) (
    input logic            clock,
    input logic            clear,
    count_stepper_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, STEP, DONE} state_e;

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_STEP);
    localparam logic [2:0]       MAX_V = 3'(MAX_STEP);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] i_q, i_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             dir_q, dir_d;
    logic             load_q, load_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic [2:0]       value_q, value_d;
    logic [2:0]       step;
    logic [WIDTH-1:0] step_w;

    // Step size: MAX_STEP, or the small remainder (which then fits 3 bits).
    always_comb begin
        step   = (rem_q > MAX_W) ? MAX_V : rem_q[2:0];
        step_w = {{(WIDTH-3){1'b0}}, step};
    end

    // Next state and next registered outputs.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        i_d      = i_q;
        shadow_d = shadow_q;
        dir_d    = dir_q;
        load_d   = 1'b1;
        value_d  = 3'd0;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start_valid) begin
                    state_d  = LOAD;
                    load_d   = 1'b0;
                    i_d      = bus.base;
                    shadow_d = bus.base;
                    if (bus.target >= bus.base) begin
                        dir_d = 1'b1;
                        rem_d = bus.target - bus.base;
                    end else begin
                        dir_d = 1'b0;
                        rem_d = bus.base - bus.target;
                    end
                end
            end
            LOAD, STEP: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (rem_q != '0) begin
                    state_d  = STEP;
                    value_d  = step;
                    rem_d    = rem_q - step_w;
                    shadow_d = dir_q ? shadow_q + step_w
                                     : shadow_q - step_w;
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d  = (state_d == LOAD) || (state_d == STEP);
        ready_d = (state_d == IDLE);
    end

    // State and output registers with synchronous active-low clear.
    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            i_q      <= '0;
            shadow_q <= '0;
            dir_q    <= 1'b1;
            load_q   <= 1'b1;
            value_q  <= 3'd0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            i_q      <= i_d;
            shadow_q <= shadow_d;
            dir_q    <= dir_d;
            load_q   <= load_d;
            value_q  <= value_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
        end
    end

    assign bus.start_ready = ready_q;
    assign bus.load        = load_q;
    assign bus.I           = i_q;
    assign bus.direction   = dir_q;
    assign bus.value       = value_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.shadow      = shadow_q;
endmodule

// File: tb/tb_count_stepper.sv
// Bench for count_stepper: directed cases plus random commands
// against a trace-building reference model.
module tb_count_stepper;
    localparam int W = 16;

    logic clk = 1'b0;
    logic clr;

    always #5 clk = ~clk;

    count_stepper_if #(.WIDTH(W)) bus ();

    count_stepper #(.WIDTH(W), .MAX_STEP(7)) dut (
        .clock(clk),
        .clear(clr),
        .bus  (bus.slave)
    );

    typedef struct {
        int kind;
        bit sr;
        bit ld;
        bit dn;
        bit bsy;
        bit dir;
        int val;
        int i;
        int sh;
    } rec_t;

    rec_t exp_q[$];
    rec_t cur;
    rec_t nxt;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input int want);
        checks++;
        if (obs !== 32'(want)) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, obs, want, $time);
        end
    endtask

    function automatic rec_t reset_rec();
        rec_t r;
        r.kind = 0; r.sr = 1; r.ld = 1; r.dn = 0; r.bsy = 0;
        r.dir = 1; r.val = 0; r.i = 0; r.sh = 0;
        return r;
    endfunction

    function automatic rec_t idle_rec(input rec_t h);
        rec_t r;
        r = h;
        r.kind = 0; r.sr = 1; r.ld = 1; r.dn = 0; r.bsy = 0;
        r.val = 0;
        return r;
    endfunction

    // Full expected trace of a command: LOAD, steps, DONE.
    task automatic build(input int b, input int t);
        rec_t r;
        int   d;
        int   n;
        int   trav;
        bit   up;
        up = (t >= b);
        d  = up ? t - b : b - t;
        n  = (d + 6) / 7;
        r.kind = 1; r.sr = 0; r.ld = 0; r.dn = 0; r.bsy = 1;
        r.dir = up; r.val = 0; r.i = b; r.sh = b;
        exp_q.push_back(r);
        for (int k = 1; k <= n; k++) begin
            trav   = (7 * k < d) ? 7 * k : d;
            r.kind = 2;
            r.ld   = 1;
            r.val  = trav - 7 * (k - 1);
            r.sh   = up ? b + trav : b - trav;
            exp_q.push_back(r);
        end
        r.kind = 3; r.ld = 1; r.dn = 1; r.bsy = 0; r.sr = 0;
        r.val = 0; r.sh = t;
        exp_q.push_back(r);
    endtask

    task automatic compare();
        chk("start_ready", 32'(bus.start_ready), int'(cur.sr));
        chk("load",        32'(bus.load),        int'(cur.ld));
        chk("done",        32'(bus.done),        int'(cur.dn));
        chk("busy",        32'(bus.busy),        int'(cur.bsy));
        chk("direction",   32'(bus.direction),   int'(cur.dir));
        chk("value",       32'(bus.value),       cur.val);
        chk("I",           32'(bus.I),           cur.i);
        chk("shadow",      32'(bus.shadow),      cur.sh);
    endtask

    // One clock: check outputs, drive inputs, advance model.
    task automatic cyc(input bit c, input bit sv, input bit ab,
                       input logic [15:0] b, input logic [15:0] t);
        compare();
        clr             = c;
        bus.start_valid = sv;
        bus.abort       = ab;
        bus.base        = b;
        bus.target      = t;
        if (!c) begin
            exp_q.delete();
            nxt = reset_rec();
        end else if (cur.kind == 0 && sv) begin
            build(int'(b), int'(t));
            nxt = exp_q.pop_front();
        end else if ((cur.kind == 1 || cur.kind == 2) && ab) begin
            exp_q.delete();
            nxt = idle_rec(cur);
        end else if (exp_q.size() > 0) begin
            nxt = exp_q.pop_front();
        end else begin
            nxt = idle_rec(cur);
        end
        @(posedge clk);
        @(negedge clk);
        cur = nxt;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
    endtask

    initial begin
        logic [15:0] rb;
        logic [15:0] rt;
        clr             = 1'b0;
        bus.start_valid = 1'b0;
        bus.abort       = 1'b0;
        bus.base        = '0;
        bus.target      = '0;
        @(posedge clk);
        @(negedge clk);
        cur = reset_rec();

        cyc(1'b0, 1'b1, 1'b1, 16'd3, 16'd9);
        cyc(1'b0, 1'b1, 1'b0, 16'd3, 16'd9);
        idle(2);

        cyc(1'b1, 1'b1, 1'b0, 16'd0, 16'd20);
        idle(7);
        cyc(1'b1, 1'b1, 1'b0, 16'd100, 16'd90);
        idle(5);
        cyc(1'b1, 1'b1, 1'b0, 16'd5, 16'd5);
        idle(4);

        cyc(1'b1, 1'b1, 1'b1, 16'd0, 16'hFFFF);
        idle(9366);

        cyc(1'b1, 1'b1, 1'b0, 16'd0, 16'd20);
        idle(2);
        cyc(1'b1, 1'b1, 1'b0, 16'd50, 16'd60);
        idle(6);

        cyc(1'b1, 1'b1, 1'b0, 16'd0, 16'd20);
        idle(2);
        cyc(1'b1, 1'b0, 1'b1, 16'd0, 16'd0);
        idle(3);

        cyc(1'b1, 1'b1, 1'b0, 16'd0, 16'd20);
        idle(2);
        cyc(1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
        idle(3);

        cyc(1'b1, 1'b1, 1'b0, 16'd0, 16'd3);
        idle(2);
        cyc(1'b1, 1'b0, 1'b1, 16'd0, 16'd0);
        cyc(1'b1, 1'b0, 1'b1, 16'd0, 16'd0);
        idle(2);

        for (int n = 0; n < 3000; n++) begin
            rb = 16'($urandom);
            if ($urandom_range(0, 7) == 0)
                rt = 16'($urandom);
            else
                rt = rb + 16'($urandom_range(0, 60)) - 16'd30;
            cyc($urandom_range(0, 63) != 0,
                $urandom_range(0, 2) == 0,
                $urandom_range(0, 31) == 0,
                rb, rt);
        end
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
